mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one downstream memory port between the pipeline's instruction-fetch
//   (imem) and load/store (dmem) requesters. Sits between the IF/MEM stages and
//   the memory/cache. One transaction outstanding at a time, registered request
//   outputs, dmem priority with a streak limit so fetch cannot starve.
// PARAMETERS
//   ADDR_W           32  byte address width
//   DATA_W           32  data width (mask width = DATA_W/8)
//   MAX_DMEM_STREAK  4   max consecutive dmem grants while imem waits (>=1)
// PORTS
//   clk             in   1         clock, all state on rising edge
//   rst_n           in   1         asynchronous active-low reset
//   imem_addr       in   ADDR_W    fetch address, held until imem_resp
//   imem_rmask      in   DATA_W/8  fetch byte mask; nonzero = request
//   imem_rdata      out  DATA_W    fetch data, valid with imem_resp
//   imem_resp       out  1         1-cycle fetch completion pulse
//   dmem_addr       in   ADDR_W    load/store address, held until dmem_resp
//   dmem_rmask      in   DATA_W/8  load byte mask
//   dmem_wmask      in   DATA_W/8  store byte mask
//   dmem_wdata      in   DATA_W    store data
//   dmem_rdata      out  DATA_W    load data, valid with dmem_resp
//   dmem_resp       out  1         1-cycle load/store completion pulse
//   mem_addr        out  ADDR_W    downstream address (registered)
//   mem_rmask       out  DATA_W/8  downstream read mask (registered)
//   mem_wmask       out  DATA_W/8  downstream write mask (registered)
//   mem_wdata       out  DATA_W    downstream write data (registered)
//   mem_rdata       in   DATA_W    downstream read data
//   mem_resp        in   1         downstream completion pulse
//   spurious_resp   out  1         sticky: mem_resp seen while IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, streak=0, all outputs 0, spurious_resp=0.
//   Request: imem_req = |imem_rmask; dmem_req = |dmem_rmask | |dmem_wmask.
//     dmem with nonzero wmask is a write; its rmask is forced to 0 downstream.
//   States: IDLE, BUSY_I, BUSY_D.
//   IDLE: if dmem_req and (!imem_req or streak<MAX_DMEM_STREAK) -> BUSY_D;
//     else if imem_req -> BUSY_I; else stay. Grant registers addr/masks/wdata
//     into mem_* on the same edge (mem request visible cycle after grant cycle).
//   BUSY_x: mem_* held stable. On mem_resp: route mem_rdata combinationally to
//     x_rdata, pulse x_resp that cycle, clear mem_rmask/mem_wmask on the edge,
//     -> IDLE. Min latency req-to-resp = 2 cycles (grant, then 1-cycle memory).
//   No back-to-back grant: always one IDLE cycle after resp (requester drops or
//     updates its request on the resp cycle; IDLE must not re-grant stale req).
//   Streak: on dmem grant with imem_req high, streak++ (saturate); on imem grant
//     or dmem grant with imem_req low, streak=0.
//   Non-granted x_resp=0; non-granted x_rdata=0 (never forward to wrong side).
//   mem_resp in IDLE: ignored (no resp pulses), spurious_resp set until reset.
//   Reset mid-transaction: aborted, no resp issued; downstream shares rst_n.
//   Requester changing addr/mask while BUSY is a protocol violation; arbiter
//     keeps the latched values (assertion in bench).
// TESTING
//   imem_rmask=4'hF addr=0x6000_0000, mem_resp 1 cycle after mem_rmask rises
//     -> mem_addr=0x6000_0000, imem_resp pulse 2 cycles after request, rdata passes.
//   Simultaneous imem load + dmem sw (wmask=4'hF, wdata=0xDEADBEEF) -> dmem granted
//     first, mem_rmask=0, mem_wmask=4'hF; imem granted after IDLE cycle.
//   dmem requests back-to-back 6 times with imem held, MAX_DMEM_STREAK=4 -> grant
//     order D,D,D,D,I,D,D; streak resets on I.
//   dmem rmask=4'h3 and wmask=4'h3 together -> treated as write, mem_rmask=0.
//   Assert rst_n low while BUSY_D -> all mem_* and resp outputs 0 immediately,
//     state IDLE, no dmem_resp after release.
//   mem_resp pulse with no request -> no imem/dmem resp, spurious_resp=1 sticky.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the instruction
// fetch (imem) and load/store (dmem) requesters. Only one transaction is in
// flight at a time. The downstream request is registered. dmem has priority,
// but a streak limit stops it from starving fetch.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_DMEM_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   imem_addr,
   input  logic [DATA_W/8-1:0] imem_rmask,
   output logic [DATA_W-1:0]   imem_rdata,
   output logic                imem_resp,
   input  logic [ADDR_W-1:0]   dmem_addr,
   input  logic [DATA_W/8-1:0] dmem_rmask,
   input  logic [DATA_W/8-1:0] dmem_wmask,
   input  logic [DATA_W-1:0]   dmem_wdata,
   output logic [DATA_W-1:0]   dmem_rdata,
   output logic                dmem_resp,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_rmask,
   output logic [DATA_W/8-1:0] mem_wmask,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_resp,
   output logic                spurious_resp
);

   localparam int MASK_W   = DATA_W / 8;
   localparam int STREAK_W = $clog2(MAX_DMEM_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DMEM_STREAK);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [MASK_W-1:0]   mem_rmask_q, mem_rmask_d;
   logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                spurious_q, spurious_d;

   logic imem_req_s;
   logic dmem_req_s;
   logic dmem_is_wr_s;
   logic grant_d_s;
   logic grant_i_s;

   // Request decode and the grant decision that is taken while IDLE.
   always_comb begin
      imem_req_s   = |imem_rmask;
      dmem_is_wr_s = |dmem_wmask;
      dmem_req_s   = (|dmem_rmask) | dmem_is_wr_s;
      grant_d_s    = dmem_req_s && (!imem_req_s || (streak_q < STREAK_MAX));
      grant_i_s    = !grant_d_s && imem_req_s;
   end

   // State, streak, latched downstream request and the sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         streak_q    <= {STREAK_W{1'b0}};
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_rmask_q <= {MASK_W{1'b0}};
         mem_wmask_q <= {MASK_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         mem_addr_q  <= mem_addr_d;
         mem_rmask_q <= mem_rmask_d;
         mem_wmask_q <= mem_wmask_d;
         mem_wdata_q <= mem_wdata_d;
         spurious_q  <= spurious_d;
      end
   end

   // Next state and streak. A response always returns to IDLE, so a new grant
   // is based on the request the requester presents after seeing its response.
   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      spurious_d = spurious_q | ((state_q == ST_IDLE) & mem_resp);
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s) begin
               state_d = ST_BUSY_D;
               if (imem_req_s) begin
                  streak_d = (streak_q == STREAK_MAX) ? streak_q
                                                      : streak_q + STREAK_W'(1);
               end else begin
                  streak_d = {STREAK_W{1'b0}};
               end
            end else if (grant_i_s) begin
               state_d  = ST_BUSY_I;
               streak_d = {STREAK_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_resp) begin
               state_d = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            streak_d = {STREAK_W{1'b0}};
         end
      endcase
   end

   // Downstream request capture and routing of the response to the owner only.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_rmask_d = mem_rmask_q;
      mem_wmask_d = mem_wmask_q;
      mem_wdata_d = mem_wdata_q;
      imem_resp   = (state_q == ST_BUSY_I) & mem_resp;
      dmem_resp   = (state_q == ST_BUSY_D) & mem_resp;
      imem_rdata  = imem_resp ? mem_rdata : {DATA_W{1'b0}};
      dmem_rdata  = dmem_resp ? mem_rdata : {DATA_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s) begin
               mem_addr_d  = dmem_addr;
               mem_rmask_d = dmem_is_wr_s ? {MASK_W{1'b0}} : dmem_rmask;
               mem_wmask_d = dmem_wmask;
               mem_wdata_d = dmem_wdata;
            end else if (grant_i_s) begin
               mem_addr_d  = imem_addr;
               mem_rmask_d = imem_rmask;
               mem_wmask_d = {MASK_W{1'b0}};
               mem_wdata_d = {DATA_W{1'b0}};
            end else begin
               mem_rmask_d = {MASK_W{1'b0}};
               mem_wmask_d = {MASK_W{1'b0}};
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_resp) begin
               mem_rmask_d = {MASK_W{1'b0}};
               mem_wmask_d = {MASK_W{1'b0}};
            end else begin
               mem_rmask_d = mem_rmask_q;
               mem_wmask_d = mem_wmask_q;
            end
         end
         default: begin
            mem_rmask_d = {MASK_W{1'b0}};
            mem_wmask_d = {MASK_W{1'b0}};
         end
      endcase
   end

   assign mem_addr      = mem_addr_q;
   assign mem_rmask     = mem_rmask_q;
   assign mem_wmask     = mem_wmask_q;
   assign mem_wdata     = mem_wdata_q;
   assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It uses random requesters, a random-latency
// memory and a transaction-level reference model. It also runs directed
// scenarios for the grant order, write masking, reset abort and spurious
// responses.
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MW   = DW / 8;
   localparam int MAXS = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic [MW-1:0] imem_rmask;
   logic [DW-1:0] imem_rdata;
   logic          imem_resp;
   logic [AW-1:0] dmem_addr;
   logic [MW-1:0] dmem_rmask;
   logic [MW-1:0] dmem_wmask;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_resp;
   logic [AW-1:0] mem_addr;
   logic [MW-1:0] mem_rmask;
   logic [MW-1:0] mem_wmask;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_resp;
   logic          spurious_resp;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DMEM_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .spurious_resp(spurious_resp)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Requester intent: what each side is currently asking for.
   bit            i_pend, d_pend;
   logic [AW-1:0] i_addr, d_addr;
   logic [MW-1:0] i_mask, d_rmask, d_wmask;
   logic [DW-1:0] d_wdata;

   // Reference model: owner of the port (0 none, 1 imem, 2 dmem), dmem wins
   // in a row while imem waited, cycles left until the memory answers, and
   // the downstream request the port should be showing.
   int            m_owner, m_streak, m_wait;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   logic [MW-1:0] e_rmask, e_wmask;
   bit            e_spur;

   int  p_i, p_d, fix_lat;
   bit  inject_spur;
   byte resp_log[$];
   int  i_resp_cyc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_owner = 0; m_streak = 0; m_wait = 0;
      e_addr = '0; e_wdata = '0; e_rmask = '0; e_wmask = '0; e_spur = 1'b0;
      i_pend = 1'b0; d_pend = 1'b0;
   endtask

   // One clock cycle: drive the memory and requesters, check the outputs,
   // then advance the reference model across the next rising edge.
   task automatic step();
      logic          exp_ir, exp_dr;
      logic [DW-1:0] exp_rd;
      @(negedge clk);
      cyc++;
      mem_resp  = 1'b0;
      mem_rdata = $urandom;
      if (m_owner != 0) begin
         m_wait--;
         if (m_wait == 0) mem_resp = 1'b1;
      end else if (inject_spur) begin
         mem_resp = 1'b1;
      end
      if (!i_pend && (int'($urandom_range(0, 99)) < p_i)) begin
         i_pend = 1'b1;
         i_addr = $urandom & 32'hFFFF_FFFC;
         i_mask = MW'($urandom_range(1, 15));
      end
      if (!d_pend && (int'($urandom_range(0, 99)) < p_d)) begin
         d_pend  = 1'b1;
         d_addr  = $urandom & 32'hFFFF_FFFC;
         d_wdata = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            d_wmask = MW'($urandom_range(1, 15));
            d_rmask = MW'($urandom_range(0, 15));
         end else begin
            d_wmask = 4'h0;
            d_rmask = MW'($urandom_range(1, 15));
         end
      end
      imem_addr  = i_addr;
      imem_rmask = i_pend ? i_mask : 4'h0;
      dmem_addr  = d_addr;
      dmem_rmask = d_pend ? d_rmask : 4'h0;
      dmem_wmask = d_pend ? d_wmask : 4'h0;
      dmem_wdata = d_wdata;
      #1;
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_rmask", mem_rmask, e_rmask);
      check_eq("mem_wmask", mem_wmask, e_wmask);
      check_eq("mem_wdata", mem_wdata, e_wdata);
      check_eq("spurious_resp", spurious_resp, e_spur);
      exp_ir = (m_owner == 1) && mem_resp;
      exp_dr = (m_owner == 2) && mem_resp;
      check_eq("imem_resp", imem_resp, exp_ir);
      check_eq("dmem_resp", dmem_resp, exp_dr);
      exp_rd = exp_ir ? mem_rdata : 32'h0;
      check_eq("imem_rdata", imem_rdata, exp_rd);
      exp_rd = exp_dr ? mem_rdata : 32'h0;
      check_eq("dmem_rdata", dmem_rdata, exp_rd);
      if (imem_resp) begin
         resp_log.push_back("I");
         i_resp_cyc = cyc;
      end
      if (dmem_resp) resp_log.push_back("D");
      if (m_owner != 0) begin
         if (mem_resp) begin
            if (m_owner == 1) i_pend = 1'b0;
            else d_pend = 1'b0;
            e_rmask = 4'h0;
            e_wmask = 4'h0;
            m_owner = 0;
         end
      end else begin
         if (mem_resp) e_spur = 1'b1;
         if (d_pend && (!i_pend || m_streak < MAXS)) begin
            m_owner  = 2;
            m_streak = i_pend ? m_streak + 1 : 0;
            e_addr   = d_addr;
            e_wdata  = d_wdata;
            e_wmask  = d_wmask;
            e_rmask  = (d_wmask != 4'h0) ? 4'h0 : d_rmask;
            m_wait   = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 3));
         end else if (i_pend) begin
            m_owner  = 1;
            m_streak = 0;
            e_addr   = i_addr;
            e_rmask  = i_mask;
            e_wmask  = 4'h0;
            e_wdata  = 32'h0;
            m_wait   = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 3));
         end
      end
      @(posedge clk);
   endtask

   task automatic drain(input string tag);
      int busy;
      p_i = 0;
      p_d = 0;
      for (int k = 0; k < 100 && (i_pend || d_pend || m_owner != 0); k++) step();
      busy = (i_pend || d_pend || m_owner != 0) ? 1 : 0;
      check_eq(tag, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_rmask = 4'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; mem_resp = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   string exp_order;
   int    req_cyc;
   int    empty_log;

   initial begin
      rst_n = 1'b0;
      imem_addr = '0; imem_rmask = '0; dmem_addr = '0; dmem_rmask = '0;
      dmem_wmask = '0; dmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      i_addr = '0; d_addr = '0; i_mask = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
      p_i = 0; p_d = 0; fix_lat = 0; inject_spur = 1'b0; i_resp_cyc = 0;
      model_clear();
      #12;
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_rmask", mem_rmask, 4'h0);
      check_eq("rst_mem_wmask", mem_wmask, 4'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_imem_resp", imem_resp, 1'b0);
      check_eq("rst_dmem_resp", dmem_resp, 1'b0);
      check_eq("rst_spurious", spurious_resp, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single fetch with a memory that answers one cycle after the request.
      fix_lat = 2;
      i_pend = 1'b1; i_addr = 32'h6000_0000; i_mask = 4'hF;
      req_cyc = cyc + 1;
      step();
      #1;
      check_eq("fetch_addr", mem_addr, 32'h6000_0000);
      check_eq("fetch_rmask", mem_rmask, 4'hF);
      drain("fetch_done");
      check_eq("fetch_latency", i_resp_cyc - req_cyc, 2);

      // Fetch and store arrive together: the store goes first.
      resp_log.delete();
      fix_lat = 1;
      i_pend = 1'b1; i_addr = 32'h0000_1000; i_mask = 4'hF;
      d_pend = 1'b1; d_addr = 32'h0000_2000; d_rmask = 4'h0; d_wmask = 4'hF;
      d_wdata = 32'hDEAD_BEEF;
      step();
      #1;
      check_eq("sw_rmask", mem_rmask, 4'h0);
      check_eq("sw_wmask", mem_wmask, 4'hF);
      check_eq("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      drain("sw_done");
      check_eq("sw_count", resp_log.size(), 2);
      if (resp_log.size() == 2) begin
         check_eq("sw_first", resp_log[0], "D");
         check_eq("sw_second", resp_log[1], "I");
      end

      // Read and write masks together: the request is treated as a write.
      d_pend = 1'b1; d_addr = 32'h0000_3000; d_rmask = 4'h3; d_wmask = 4'h3;
      d_wdata = 32'h1234_5678;
      step();
      #1;
      check_eq("rw_rmask", mem_rmask, 4'h0);
      check_eq("rw_wmask", mem_wmask, 4'h3);
      drain("rw_done");

      // Both sides always requesting: dmem wins until the streak limit.
      do_reset();
      resp_log.delete();
      fix_lat = 1; p_i = 100; p_d = 100;
      for (int k = 0; k < 100 && resp_log.size() < 7; k++) step();
      p_i = 0; p_d = 0;
      check_eq("streak_count_ok", (resp_log.size() >= 7) ? 1 : 0, 1);
      exp_order = "DDDDIDD";
      if (resp_log.size() >= 7) begin
         for (int k = 0; k < 7; k++) check_eq("streak_order", resp_log[k], exp_order[k]);
      end
      drain("streak_done");

      // Random traffic with random memory latency.
      fix_lat = 0; p_i = 50; p_d = 50;
      repeat (600) step();
      drain("random_done");

      // Reset while a store is in flight aborts it without a response.
      d_pend = 1'b1; d_addr = 32'h0000_4000; d_rmask = 4'h0; d_wmask = 4'hF;
      d_wdata = 32'hCAFE_F00D;
      fix_lat = 3;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b0;
      mem_resp = 1'b0;
      imem_rmask = 4'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0;
      #1;
      check_eq("abort_mem_addr", mem_addr, 32'h0);
      check_eq("abort_mem_wmask", mem_wmask, 4'h0);
      check_eq("abort_mem_rmask", mem_rmask, 4'h0);
      check_eq("abort_mem_wdata", mem_wdata, 32'h0);
      check_eq("abort_dmem_resp", dmem_resp, 1'b0);
      check_eq("abort_imem_resp", imem_resp, 1'b0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      resp_log.delete();
      fix_lat = 0;
      repeat (5) step();
      empty_log = resp_log.size();
      check_eq("abort_no_resp", empty_log, 0);

      // A memory response with nothing outstanding sets the sticky flag.
      inject_spur = 1'b1;
      step();
      inject_spur = 1'b0;
      step();
      check_eq("spurious_set", spurious_resp, 1'b1);
      p_i = 40; p_d = 40;
      repeat (20) step();
      drain("spurious_done");
      check_eq("spurious_sticky", spurious_resp, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
